melody_sequencer: RTL
=====================

Name: melody_sequencer

Overview:
- Upstream stage of the I2S tone player: walks a score ROM and drives the {octave, note} pair that the note-LUT/I2S transmitter consumes.
- Replaces the hard-wired note_cnt case table with a playable sequencer that provides:
  - per-note durations
  - selectable tempo
  - articulation gaps
  - start/stop control
  - looping
  - end-of-song signalling

Parameters:
- ADDR_W, 6, score ROM address width (max 64 entries).
- TICK_DIV, 12500000, clocks per duration tick at tempo 0 (0.25 s at 50 MHz). Bench uses 8.
- GAP_TICKS, 1, trailing ticks of each note forced to silence for articulation.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- start  in  1  pulse; (re)start song from address 0.
- stop  in  1  pulse; abort playback.
- loop  in  1  level; restart automatically at end of song.
- tempo  in  2  divider shift: tick period = TICK_DIV >> tempo.
- rom_addr  out  ADDR_W  score ROM address.
- rom_data  in  11  entry {octave[10:8], note[7:4], dur[3:0]}; combinational read of rom_addr.
- octave  out  3  current octave to LUT.
- note  out  4  current note: 0..11 = C..B, 12 = silence.
- note_strobe  out  1  one-cycle pulse when a new entry starts sounding.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse on natural end of song (not on stop).

Behaviour:
- Reset values: rom_addr 0, octave 0, note 12, note_strobe 0, busy 0, done 0, state IDLE. All outputs are registered.
- Entry decoding:
  - note 12 = rest.
  - note 15 = end marker.
  - note 13/14 = treated as rest.
  - Duration = dur+1 ticks (1..16).
- Tick prescaler:
  - Counts 0..(TICK_DIV>>tempo)-1 and pulses tick on the terminal count.
  - Cleared on start, so the first note is full length.
  - A tempo change takes effect at the next wrap. If the count already exceeds the new terminal value, it wraps at its natural overflow to 0.
- States: IDLE, FETCH, PLAY.
  - IDLE: note=12, octave=0, busy=0. start -> rom_addr<=0, clear prescaler, go to FETCH.
  - FETCH (exactly 1 cycle):
    - End marker: if loop=1 and rom_addr!=0, set rom_addr<=0 and stay in FETCH. Otherwise pulse done and go to IDLE with silence. An end marker at address 0 always terminates, which prevents a livelock.
    - Any other entry: latch octave/note, remain<=dur+1, note_strobe=1 in the next cycle, go to PLAY.
  - PLAY:
    - On each tick, remain decrements.
    - Output note while remain > GAP_TICKS. Output silence (note=12, octave held) while remain <= GAP_TICKS and dur+1 > GAP_TICKS.
    - Notes no longer than GAP_TICKS play without a gap.
    - When tick and remain==1: if rom_addr is the last address (all ones), handle as an end marker. Otherwise rom_addr<=rom_addr+1 and go to FETCH.
- Latency:
  - start asserted at cycle t gives FETCH at t+1, with rom_addr=0 valid from t+1.
  - note/octave/note_strobe valid at t+2.
  - Between consecutive entries there is one FETCH cycle; the previous output is held through it.
- Priorities:
  - stop beats start in the same cycle.
  - stop in any state: go to IDLE next cycle, note=12, octave=0, no done.
  - start while busy: restart from address 0 (prescaler cleared, no done).
- Reset mid-playback: immediate return to reset values.
- loop sampled only in FETCH/end handling. Deasserting it mid-song ends at the next end marker.

Decomposition:
- Shared package/header `melody_pkg`:
  - note code constants C..B, SILENCE=12, END_MARK=15
  - entry field positions/widths (OCT_MSB, NOTE_MSB, DUR_MSB)
  - state encodings
- One sub-module `tick_prescaler` (clk, reset, clear, tempo -> tick), parameterised by TICK_DIV.
- The score ROM stays outside, so different soundtracks can be swapped.

Test Plan:
- TICK_DIV=8, tempo 0, ROM {E o1 dur1, B o0 dur0, END}; pulse start at t -> addr0 note 4 octave 1 from t+2 for 8 cycles, then note 12 for 8 cycles (gap). Next FETCH: B (note 11) for 8 cycles; then done pulse and busy=0.
- Same ROM, tempo=2 -> tick every 2 cycles; E sounds 2 cycles plus a 2-cycle gap; total song length ~= 1/4 of tempo 0.
- loop=1, same ROM -> after END, rom_addr returns to 0 with no done, note_strobe for E again. Deassert loop -> single done at the next END.
- Mid-note stop -> note=12, busy=0 the next cycle, no done. Simultaneous start+stop -> stays IDLE.
- ROM with END at address 0 and loop=1 -> done one cycle after FETCH, IDLE, no repeated fetch.
- ROM filled with 64 rest/dur0 entries and no END -> after address 63, done pulse and IDLE. Assert reset mid-song -> all outputs at reset values immediately.

Source files
------------

// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - shared note codes, score entry layout and sequencer states
package melody_pkg;

  localparam logic [3:0] NOTE_C   = 4'd0;
  localparam logic [3:0] NOTE_CS  = 4'd1;
  localparam logic [3:0] NOTE_D   = 4'd2;
  localparam logic [3:0] NOTE_DS  = 4'd3;
  localparam logic [3:0] NOTE_E   = 4'd4;
  localparam logic [3:0] NOTE_F   = 4'd5;
  localparam logic [3:0] NOTE_FS  = 4'd6;
  localparam logic [3:0] NOTE_G   = 4'd7;
  localparam logic [3:0] NOTE_GS  = 4'd8;
  localparam logic [3:0] NOTE_A   = 4'd9;
  localparam logic [3:0] NOTE_AS  = 4'd10;
  localparam logic [3:0] NOTE_B   = 4'd11;
  localparam logic [3:0] SILENCE  = 4'd12;
  localparam logic [3:0] END_MARK = 4'd15;

  // score entry = {octave[10:8], note[7:4], dur[3:0]}
  localparam int OCT_MSB  = 10;
  localparam int NOTE_MSB = 7;
  localparam int DUR_MSB  = 3;
  localparam int OCT_W    = 3;
  localparam int NOTE_W   = 4;
  localparam int DUR_W    = 4;
  localparam int ENTRY_W  = OCT_W + NOTE_W + DUR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  // codes 13/14 are unused by the score format and sound as rests
  function automatic logic [3:0] sounding_note(input logic [3:0] n);
    return (n > NOTE_B) ? SILENCE : n;
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// rtl/melody_sequencer_if.sv - control, score ROM and note output bundle of the sequencer
interface melody_sequencer_if
  import melody_pkg::*;
#(
  parameter int ADDR_W = 6
) ();

  logic               start;
  logic               stop;
  logic               loop;
  logic [1:0]         tempo;
  logic [ADDR_W-1:0]  rom_addr;
  logic [ENTRY_W-1:0] rom_data;
  logic [OCT_W-1:0]   octave;
  logic [NOTE_W-1:0]  note;
  logic               note_strobe;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, loop, tempo, rom_data,
    input  rom_addr, octave, note, note_strobe, busy, done
  );

  modport slave (
    input  start, stop, loop, tempo, rom_data,
    output rom_addr, octave, note, note_strobe, busy, done
  );

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - duration tick generator, period TICK_DIV >> tempo clocks
module tick_prescaler #(
  parameter int TICK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [1:0] tempo,
  output logic       tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM0 = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_term;
  logic [CW-1:0] w_term;
  logic [31:0]   w_div;

  assign w_div  = 32'(TICK_DIV) >> tempo;
  assign w_term = (w_div == 32'd0) ? '0 : CW'(w_div - 32'd1);
  assign tick   = (r_cnt == r_term);

  // terminal count is re-sampled only at clear or wrap, so tempo changes land on a tick boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_term <= TERM0;
    end else if (clear || tick) begin
      r_cnt  <= '0;
      r_term <= w_term;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - walks the score ROM and drives {octave, note} to the tone player
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int TICK_DIV  = 12500000,
  parameter int GAP_TICKS = 1
) (
  input logic               clk,
  input logic               reset,
  melody_sequencer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [4:0]        GAP       = 5'(GAP_TICKS);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [OCT_W-1:0]  r_octave, w_octave_nxt;
  logic [NOTE_W-1:0] r_note, w_note_nxt;
  logic [NOTE_W-1:0] r_ent_note, w_ent_note_nxt;
  logic [4:0]        r_remain, w_remain_nxt;
  logic              r_gap_en, w_gap_en_nxt;
  logic              r_strobe, w_strobe_nxt;
  logic              r_done, w_done_nxt;
  logic              r_busy;
  logic              w_clear;
  logic              w_tick;
  logic              w_end;
  logic [NOTE_W-1:0] w_rom_note;
  logic [4:0]        w_rom_len;

  assign w_rom_note = bus.rom_data[NOTE_MSB -: NOTE_W];
  assign w_rom_len  = {1'b0, bus.rom_data[DUR_MSB -: DUR_W]} + 5'd1;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .tempo (bus.tempo),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_octave_nxt   = r_octave;
    w_note_nxt     = r_note;
    w_ent_note_nxt = r_ent_note;
    w_remain_nxt   = r_remain;
    w_gap_en_nxt   = r_gap_en;
    w_strobe_nxt   = 1'b0;
    w_done_nxt     = 1'b0;
    w_clear        = 1'b0;
    w_end          = 1'b0;

    case (r_state)
      ST_IDLE: ;
      ST_FETCH: begin
        if (w_rom_note == END_MARK) begin
          w_end = 1'b1;
        end else begin
          w_ent_note_nxt = sounding_note(w_rom_note);
          w_note_nxt     = sounding_note(w_rom_note);
          w_octave_nxt   = bus.rom_data[OCT_MSB -: OCT_W];
          w_remain_nxt   = w_rom_len;
          w_gap_en_nxt   = (w_rom_len > GAP);
          w_strobe_nxt   = 1'b1;
          w_state_nxt    = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // output lags remain by one cycle; the last value is held through the next FETCH
        w_note_nxt = ((r_remain > GAP) || !r_gap_en) ? r_ent_note : SILENCE;
        if (w_tick) begin
          w_remain_nxt = r_remain - 5'd1;
          if (r_remain == 5'd1) begin
            if (r_addr == LAST_ADDR) begin
              w_end = 1'b1;
            end else begin
              w_addr_nxt  = r_addr + 1'b1;
              w_state_nxt = ST_FETCH;
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // an end marker at address 0 never loops, otherwise an empty score would spin in FETCH
    if (w_end) begin
      if (bus.loop && (r_addr != '0)) begin
        w_addr_nxt  = '0;
        w_state_nxt = ST_FETCH;
      end else begin
        w_done_nxt   = 1'b1;
        w_state_nxt  = ST_IDLE;
        w_note_nxt   = SILENCE;
        w_octave_nxt = '0;
      end
    end

    if (bus.stop) begin
      w_state_nxt  = ST_IDLE;
      w_addr_nxt   = '0;
      w_note_nxt   = SILENCE;
      w_octave_nxt = '0;
      w_strobe_nxt = 1'b0;
      w_done_nxt   = 1'b0;
    end else if (bus.start) begin
      w_state_nxt  = ST_FETCH;
      w_addr_nxt   = '0;
      w_clear      = 1'b1;
      w_strobe_nxt = 1'b0;
      w_done_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_octave   <= '0;
      r_note     <= SILENCE;
      r_ent_note <= SILENCE;
      r_remain   <= '0;
      r_gap_en   <= 1'b0;
      r_strobe   <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_octave   <= w_octave_nxt;
      r_note     <= w_note_nxt;
      r_ent_note <= w_ent_note_nxt;
      r_remain   <= w_remain_nxt;
      r_gap_en   <= w_gap_en_nxt;
      r_strobe   <= w_strobe_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.rom_addr    = r_addr;
  assign bus.octave      = r_octave;
  assign bus.note        = r_note;
  assign bus.note_strobe = r_strobe;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule
